// File: rtl/cal_ctrl.sv
// Command sequencer for the UART calculator: validates a decoded command, runs one ALU
// operation with a timeout, then streams the result (or "ERR") to the UART transmitter.
module cal_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  dtype_i,
  input  logic [4:0]  operator_i,
  input  logic [15:0] src1_i,
  input  logic [15:0] src2_i,
  input  logic        parser_done_i,
  output logic        alu_start_o,
  output logic [4:0]  alu_op_o,
  output logic        alu_signed_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [2:0] {StIdle, StCheck, StStart, StWait, StSend, StErrs} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [3:0]  dtype_q;
  logic [4:0]  alu_op_q;
  logic        alu_signed_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic        alu_start_q;
  logic [15:0] tmo_q;
  logic [31:0] result_q;
  logic [3:0]  idx_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic [7:0]  drop_cnt_q;

  logic        cmd_ok;
  logic [3:0]  last_idx;
  logic [3:0]  idx_next;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Bytes 0..7 are hex digits, MS nibble first, then CR LF.
  function automatic logic [7:0] res_byte(input logic [31:0] res, input logic [3:0] idx);
    logic [31:0] sh;
    logic [7:0]  b;
    sh = res << {idx[2:0], 2'b00};
    if (idx < 4'd8)       b = hex_char(sh[31:28]);
    else if (idx == 4'd8) b = 8'h0D;
    else                  b = 8'h0A;
    return b;
  endfunction

  function automatic logic [7:0] err_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:       b = 8'h45;
      4'd1, 4'd2: b = 8'h52;
      4'd3:       b = 8'h0D;
      default:    b = 8'h0A;
    endcase
    return b;
  endfunction

  assign cmd_ok   = ((dtype_q == 4'd1) || (dtype_q == 4'd2)) &&
                    (alu_op_q >= 5'd1) && (alu_op_q <= 5'd4);
  assign last_idx = (state_q == StSend) ? 4'd9 : 4'd4;
  assign idx_next = idx_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      dtype_q      <= '0;
      alu_op_q     <= '0;
      alu_signed_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_start_q  <= 1'b0;
      tmo_q        <= '0;
      result_q     <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      alu_start_q <= 1'b0;
      if (parser_done_i && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
      case (state_q)
        StIdle: begin
          if (parser_done_i) begin
            dtype_q      <= dtype_i;
            alu_op_q     <= operator_i;
            alu_signed_q <= (dtype_i == 4'd1);
            alu_a_q      <= src1_i;
            alu_b_q      <= src2_i;
            busy_q       <= 1'b1;
            state_q      <= StCheck;
          end
        end
        StCheck: begin
          if (cmd_ok) begin
            alu_start_q <= 1'b1;
            state_q     <= StStart;
          end else begin
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= err_byte(4'd0);
            state_q    <= StErrs;
          end
        end
        StStart: begin
          // The launch cycle counts toward the timeout budget.
          tmo_q   <= 16'd1;
          state_q <= StWait;
        end
        StWait: begin
          tmo_q <= tmo_q + 16'd1;
          if (alu_done_i) begin
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            if (alu_err_i) begin
              tx_data_q <= err_byte(4'd0);
              state_q   <= StErrs;
            end else begin
              result_q  <= alu_result_i;
              tx_data_q <= hex_char(alu_result_i[31:28]);
              state_q   <= StSend;
            end
          end else if (tmo_q >= TmoLast) begin
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= err_byte(4'd0);
            state_q    <= StErrs;
          end
        end
        StSend, StErrs: begin
          if (tx_ready_i) begin
            if (idx_q == last_idx) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end else begin
              idx_q     <= idx_next;
              tx_data_q <= (state_q == StSend) ? res_byte(result_q, idx_next)
                                               : err_byte(idx_next);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_start_o  = alu_start_q;
  assign alu_op_o     = alu_op_q;
  assign alu_signed_o = alu_signed_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign busy_o       = busy_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_cal_ctrl.sv
// Self-checking bench for cal_ctrl: directed commands, a byte scoreboard fed by a text model,
// and handshake stability checks on every cycle.
module tb_cal_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1, src2;
  logic        parser_done;
  logic        alu_start;
  logic [4:0]  alu_op;
  logic        alu_signed;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        alu_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  cal_ctrl #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dtype_i      (dtype),
    .operator_i   (operator),
    .src1_i       (src1),
    .src2_i       (src2),
    .parser_done_i(parser_done),
    .alu_start_o  (alu_start),
    .alu_op_o     (alu_op),
    .alu_signed_o (alu_signed),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_done_i   (alu_done),
    .alu_result_i (alu_result),
    .alu_err_i    (alu_err),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .drop_cnt_o   (drop_cnt)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         start_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  logic [7:0] lit_add [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h36, 8'h38, 8'h41, 8'h43,
                               8'h0D, 8'h0A};
  logic [7:0] lit_mul [10] = '{8'h46, 8'h46, 8'h46, 8'h45, 8'h30, 8'h30, 8'h30, 8'h31,
                               8'h0D, 8'h0A};
  logic [3:0] inv_dtype [5] = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd15};
  logic [4:0] inv_op    [5] = '{5'd1, 5'd1, 5'd0, 5'd5, 5'd31};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Text model: what the transmitter must receive for a result or an error.
  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic push_result(input logic [31:0] r);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_digit(4'((r >> (4 * i)) & 32'hF)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_err();
    string s;
    s = "ERR";
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start) start_cnt++;
      if (!rst) begin
        if (hold_pending) begin
          chk("hold_valid", tx_valid, 1);
          chk("hold_data", tx_data, hold_data);
        end
        if (tx_valid) chk("busy_while_tx", busy, 1);
        if (tx_valid && tx_ready) begin
          got_q.push_back(tx_data);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_extra: got byte 0x%0h, expected none", tx_data);
          end else begin
            chk("tx_byte", tx_data, exp_q.pop_front());
          end
        end
      end
      hold_pending = !rst && tx_valid && !tx_ready;
      hold_data    = tx_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] t, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    dtype = t; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
    tick();
    parser_done = 1'b0;
  endtask

  task automatic alu_reply(input logic [31:0] r, input logic err);
    alu_done = 1'b1; alu_result = r; alu_err = err;
    tick();
    alu_done = 1'b0; alu_err = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
    chk({name, "_idle"}, busy, 0);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  int cyc;

  initial begin
    rst = 1'b1; dtype = '0; operator = '0; src1 = '0; src2 = '0; parser_done = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_signed", alu_signed, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    rst = 1'b0;
    tick();

    // Unsigned add
    push_result(32'h000068AC); got_q.delete(); start_cnt = 0;
    issue(4'd2, 5'd1, 16'h1234, 16'h5678);
    chk("add_busy_c1", busy, 1);
    chk("add_nostart_c1", alu_start, 0);
    tick();
    chk("add_start_c2", alu_start, 1);
    chk("add_a", alu_a, 16'h1234);
    chk("add_b", alu_b, 16'h5678);
    chk("add_op", alu_op, 1);
    chk("add_signed", alu_signed, 0);
    tick();
    alu_reply(32'h000068AC, 1'b0);
    chk("add_first_valid", tx_valid, 1);
    chk("add_first_byte", tx_data, 8'h30);
    wait_idle("add", cyc);
    chk("add_send_cycles", cyc, 10);
    chk("add_start_pulses", start_cnt, 1);
    chk("add_nbytes", got_q.size(), 10);
    for (int k = 0; k < got_q.size() && k < 10; k++) chk("add_literal", got_q[k], lit_add[k]);

    // Multiply with backpressure, issued the cycle the FSM returns to IDLE
    push_result(32'hFFFE0001); got_q.delete(); start_cnt = 0;
    issue(4'd2, 5'd3, 16'hFFFF, 16'hFFFF);
    chk("mul_accepted", busy, 1);
    chk("mul_nodrop", drop_cnt, 0);
    tick();
    chk("mul_start", alu_start, 1);
    chk("mul_op", alu_op, 3);
    tick();
    alu_reply(32'hFFFE0001, 1'b0);
    tick();
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_hold_valid", tx_valid, 1);
      chk("mul_hold_byte", tx_data, 8'h46);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("mul", cyc);
    chk("mul_tail_cycles", cyc, 8);
    chk("mul_nbytes", got_q.size(), 10);
    for (int k = 0; k < got_q.size() && k < 10; k++) chk("mul_literal", got_q[k], lit_mul[k]);

    // Signed divide by zero
    push_err(); start_cnt = 0;
    issue(4'd1, 5'd4, 16'h0010, 16'h0000);
    tick();
    chk("div0_start", alu_start, 1);
    chk("div0_signed", alu_signed, 1);
    tick();
    alu_reply(32'h0, 1'b1);
    chk("div0_valid", tx_valid, 1);
    chk("div0_byte0", tx_data, 8'h45);
    wait_idle("div0", cyc);
    chk("div0_send_cycles", cyc, 5);
    chk("div0_start_pulses", start_cnt, 1);

    // Invalid type/operator combinations
    for (int v = 0; v < 5; v++) begin
      push_err(); start_cnt = 0;
      issue(inv_dtype[v], inv_op[v], 16'h0001, 16'h0001);
      chk("inv_quiet_c1", tx_valid, 0);
      tick();
      chk("inv_valid_c2", tx_valid, 1);
      chk("inv_byte_c2", tx_data, 8'h45);
      wait_idle("inv", cyc);
      chk("inv_no_start", start_cnt, 0);
    end

    // Timeout with a late alu_done during ERRS
    push_err(); start_cnt = 0;
    issue(4'd2, 5'd2, 16'h0005, 16'h0003);
    tick();
    chk("tmo_start", alu_start, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("tmo_wait_quiet", tx_valid, 0);
    end
    tick();
    chk("tmo_err_valid", tx_valid, 1);
    chk("tmo_err_byte", tx_data, 8'h45);
    alu_reply(32'h00001234, 1'b0);
    wait_idle("tmo", cyc);

    // Drops during SEND
    push_result(32'h00000003); got_q.delete(); start_cnt = 0;
    issue(4'd2, 5'd1, 16'h0001, 16'h0002);
    tick();
    tick();
    alu_reply(32'h00000003, 1'b0);
    tick();
    dtype = 4'd1; operator = 5'd4; src1 = 16'hAAAA; src2 = 16'hBBBB; parser_done = 1'b1;
    tick();
    parser_done = 1'b0;
    tick();
    parser_done = 1'b1;
    tick();
    parser_done = 1'b0;
    chk("drop_cnt_2", drop_cnt, 2);
    chk("drop_keep_a", alu_a, 16'h0001);
    chk("drop_keep_b", alu_b, 16'h0002);
    chk("drop_keep_op", alu_op, 1);
    wait_idle("drop", cyc);
    chk("drop_nbytes", got_q.size(), 10);
    chk("drop_start_pulses", start_cnt, 1);

    // Reset mid-string
    push_result(32'hDEADBEEF);
    issue(4'd2, 5'd1, 16'h1111, 16'h2222);
    tick();
    tick();
    alu_reply(32'hDEADBEEF, 1'b0);
    tick();
    tick();
    rst = 1'b1; tx_ready = 1'b0;
    tick();
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_a", alu_a, 0);
    exp_q.delete();
    rst = 1'b0; tx_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_quiet", tx_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
